// File: rtl/rvh_mmu_pkg.sv
// Shared MMU-side types: access-type encodings, miss-queue FSM states and the
// miss-entry record held in each queue slot.
package rvh_mmu_pkg;

    localparam int MQ_TRANS_ID_WIDTH = 3;
    localparam int MQ_ASID_WIDTH     = 16;
    localparam int MQ_VPN_WIDTH      = 27;
    localparam int MQ_MASK_WIDTH     = 1 << MQ_TRANS_ID_WIDTH;

    localparam logic [1:0] ACCESS_R = 2'd0;
    localparam logic [1:0] ACCESS_W = 2'd1;
    localparam logic [1:0] ACCESS_X = 2'd2;

    typedef enum logic [1:0] {
        MQ_IDLE  = 2'd0,
        MQ_ISSUE = 2'd1,
        MQ_WAIT  = 2'd2
    } mq_state_e;

    typedef struct packed {
        logic [MQ_ASID_WIDTH-1:0]     asid;
        logic [MQ_VPN_WIDTH-1:0]      vpn;
        logic [1:0]                   access_type;
        logic [MQ_TRANS_ID_WIDTH-1:0] trans_id;
        logic [MQ_MASK_WIDTH-1:0]     wake_mask;
    } miss_entry_t;

endpackage

// File: rtl/rvh_tlb_miss_queue.sv
// Miss-coalescing queue between an L1 TLB and the MMU miss port: duplicate
// misses merge into one walk, distinct misses issue in FIFO order.
//
// state | meaning
// IDLE  | no walk outstanding, queue head not yet offered
// ISSUE | head presented to MMU, waiting for mmu_req_rdy_i
// WAIT  | head accepted by MMU, waiting for the walk result
module rvh_tlb_miss_queue
    import rvh_mmu_pkg::*;
#(
    parameter int ENTRY_COUNT    = 4,
    parameter int TRANS_ID_WIDTH = MQ_TRANS_ID_WIDTH,
    parameter int ASID_WIDTH     = MQ_ASID_WIDTH,
    parameter int VPN_WIDTH      = MQ_VPN_WIDTH,
    localparam int PAGE_LVL_WIDTH = $clog2(VPN_WIDTH / 9),
    localparam int PTE_WIDTH      = 64,
    localparam int MASK_WIDTH     = 1 << TRANS_ID_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      tlb_req_vld_i,
    input  logic [TRANS_ID_WIDTH-1:0] tlb_req_trans_id_i,
    input  logic [ASID_WIDTH-1:0]     tlb_req_asid_i,
    input  logic [VPN_WIDTH-1:0]      tlb_req_vpn_i,
    input  logic [1:0]                tlb_req_access_type_i,
    output logic                      tlb_req_rdy_o,
    output logic                      mmu_req_vld_o,
    output logic [TRANS_ID_WIDTH-1:0] mmu_req_trans_id_o,
    output logic [ASID_WIDTH-1:0]     mmu_req_asid_o,
    output logic [VPN_WIDTH-1:0]      mmu_req_vpn_o,
    output logic [1:0]                mmu_req_access_type_o,
    input  logic                      mmu_req_rdy_i,
    input  logic                      mmu_resp_vld_i,
    input  logic [PTE_WIDTH-1:0]      mmu_resp_pte_i,
    input  logic [PAGE_LVL_WIDTH-1:0] mmu_resp_page_lvl_i,
    input  logic                      mmu_resp_access_fault_i,
    input  logic                      mmu_resp_page_fault_i,
    output logic                      tlb_resp_vld_o,
    output logic [MASK_WIDTH-1:0]     tlb_resp_wake_mask_o,
    output logic [ASID_WIDTH-1:0]     tlb_resp_asid_o,
    output logic [VPN_WIDTH-1:0]      tlb_resp_vpn_o,
    output logic [1:0]                tlb_resp_access_type_o,
    output logic [PTE_WIDTH-1:0]      tlb_resp_pte_o,
    output logic [PAGE_LVL_WIDTH-1:0] tlb_resp_page_lvl_o,
    output logic                      tlb_resp_access_fault_o,
    output logic                      tlb_resp_page_fault_o,
    output logic                      tlb_resp_stale_o
);

    localparam int IDX_W = $clog2(ENTRY_COUNT);
    localparam int PTR_W = IDX_W + 1;

    miss_entry_t          entry_q [ENTRY_COUNT];
    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    mq_state_e            state_q, state_d;
    logic                 stale_q, stale_d;

    logic [IDX_W-1:0]       head_idx, tail_idx;
    logic [PTR_W-1:0]       count;
    logic                   empty, full, pop, push, merge, match_any;
    logic [ENTRY_COUNT-1:0] valid, match_vec;
    logic [MASK_WIDTH-1:0]  req_onehot;
    miss_entry_t            new_entry, head_entry;

    assign head_idx   = head_q[IDX_W-1:0];
    assign tail_idx   = tail_q[IDX_W-1:0];
    assign count      = tail_q - head_q;
    assign empty      = (head_q == tail_q);
    assign full       = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
    assign head_entry = entry_q[head_idx];
    assign pop        = (state_q == MQ_WAIT) && mmu_resp_vld_i;

    // The head being popped this cycle must not absorb a merge: its wake mask
    // is already on its way to the response register.
    always_comb begin
        valid     = '0;
        match_vec = '0;
        for (int i = 0; i < ENTRY_COUNT; i++) begin
            valid[i]     = {1'b0, IDX_W'(i) - head_idx} < count;
            match_vec[i] = valid[i]
                         && (entry_q[i].asid == tlb_req_asid_i)
                         && (entry_q[i].vpn == tlb_req_vpn_i)
                         && (entry_q[i].access_type == tlb_req_access_type_i)
                         && !(pop && (IDX_W'(i) == head_idx));
        end
    end

    assign match_any     = |match_vec;
    assign tlb_req_rdy_o = !flush_i && (match_any || !full);
    assign push          = tlb_req_vld_i && tlb_req_rdy_o && !match_any;
    assign merge         = tlb_req_vld_i && tlb_req_rdy_o && match_any;

    always_comb begin
        req_onehot                     = '0;
        req_onehot[tlb_req_trans_id_i] = 1'b1;
        new_entry.asid                 = tlb_req_asid_i;
        new_entry.vpn                  = tlb_req_vpn_i;
        new_entry.access_type          = tlb_req_access_type_i;
        new_entry.trans_id             = tlb_req_trans_id_i;
        new_entry.wake_mask            = req_onehot;
    end

    // An entry already offered to the MMU cannot be withdrawn, so a flush in
    // ISSUE/WAIT keeps the head and only marks its result stale.
    always_comb begin
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
        stale_d = stale_q;
        if (flush_i) begin
            tail_d = (state_q == MQ_IDLE) ? head_q : head_q + PTR_W'(1);
        end
        if (pop) begin
            stale_d = 1'b0;
        end else if (flush_i && (state_q != MQ_IDLE)) begin
            stale_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MQ_IDLE:  if (!empty && !flush_i) state_d = MQ_ISSUE;
            MQ_ISSUE: if (mmu_req_rdy_i) state_d = MQ_WAIT;
            MQ_WAIT:  if (pop) state_d = (head_d != tail_d) ? MQ_ISSUE : MQ_IDLE;
            default:  state_d = MQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MQ_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            stale_q <= 1'b0;
            for (int i = 0; i < ENTRY_COUNT; i++) entry_q[i] <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            stale_q <= stale_d;
            for (int i = 0; i < ENTRY_COUNT; i++) begin
                if (merge && match_vec[i]) entry_q[i].wake_mask <= entry_q[i].wake_mask | req_onehot;
            end
            if (push) entry_q[tail_idx] <= new_entry;
        end
    end

    assign mmu_req_vld_o         = (state_q == MQ_ISSUE);
    assign mmu_req_trans_id_o    = head_entry.trans_id;
    assign mmu_req_asid_o        = head_entry.asid;
    assign mmu_req_vpn_o         = head_entry.vpn;
    assign mmu_req_access_type_o = head_entry.access_type;

    always_ff @(posedge clk) begin
        if (rst) begin
            tlb_resp_vld_o          <= 1'b0;
            tlb_resp_wake_mask_o    <= '0;
            tlb_resp_asid_o         <= '0;
            tlb_resp_vpn_o          <= '0;
            tlb_resp_access_type_o  <= '0;
            tlb_resp_pte_o          <= '0;
            tlb_resp_page_lvl_o     <= '0;
            tlb_resp_access_fault_o <= 1'b0;
            tlb_resp_page_fault_o   <= 1'b0;
            tlb_resp_stale_o        <= 1'b0;
        end else begin
            tlb_resp_vld_o <= pop;
            if (pop) begin
                tlb_resp_wake_mask_o    <= head_entry.wake_mask;
                tlb_resp_asid_o         <= head_entry.asid;
                tlb_resp_vpn_o          <= head_entry.vpn;
                tlb_resp_access_type_o  <= head_entry.access_type;
                tlb_resp_pte_o          <= mmu_resp_pte_i;
                tlb_resp_page_lvl_o     <= mmu_resp_page_lvl_i;
                tlb_resp_access_fault_o <= mmu_resp_access_fault_i;
                tlb_resp_page_fault_o   <= mmu_resp_page_fault_i;
                tlb_resp_stale_o        <= stale_q || flush_i;
            end
        end
    end

    a_resp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
        !(mmu_resp_vld_i && (state_q != MQ_WAIT)));

endmodule

// File: tb/tb_rvh_tlb_miss_queue.sv
// Bench for rvh_tlb_miss_queue: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-based reference model.
module tb_rvh_tlb_miss_queue;
    import rvh_mmu_pkg::*;

    localparam int N  = 4;
    localparam int TW = 3;
    localparam int AW = 16;
    localparam int VW = 27;
    localparam int LW = 2;
    localparam int PW = 64;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_i;
    logic          tlb_req_vld_i;
    logic [TW-1:0] tlb_req_trans_id_i;
    logic [AW-1:0] tlb_req_asid_i;
    logic [VW-1:0] tlb_req_vpn_i;
    logic [1:0]    tlb_req_access_type_i;
    logic          tlb_req_rdy_o;
    logic          mmu_req_vld_o;
    logic [TW-1:0] mmu_req_trans_id_o;
    logic [AW-1:0] mmu_req_asid_o;
    logic [VW-1:0] mmu_req_vpn_o;
    logic [1:0]    mmu_req_access_type_o;
    logic          mmu_req_rdy_i;
    logic          mmu_resp_vld_i;
    logic [PW-1:0] mmu_resp_pte_i;
    logic [LW-1:0] mmu_resp_page_lvl_i;
    logic          mmu_resp_access_fault_i;
    logic          mmu_resp_page_fault_i;
    logic          tlb_resp_vld_o;
    logic [MW-1:0] tlb_resp_wake_mask_o;
    logic [AW-1:0] tlb_resp_asid_o;
    logic [VW-1:0] tlb_resp_vpn_o;
    logic [1:0]    tlb_resp_access_type_o;
    logic [PW-1:0] tlb_resp_pte_o;
    logic [LW-1:0] tlb_resp_page_lvl_o;
    logic          tlb_resp_access_fault_o;
    logic          tlb_resp_page_fault_o;
    logic          tlb_resp_stale_o;

    always #5 clk = ~clk;

    rvh_tlb_miss_queue dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .tlb_req_vld_i(tlb_req_vld_i), .tlb_req_trans_id_i(tlb_req_trans_id_i),
        .tlb_req_asid_i(tlb_req_asid_i), .tlb_req_vpn_i(tlb_req_vpn_i),
        .tlb_req_access_type_i(tlb_req_access_type_i), .tlb_req_rdy_o(tlb_req_rdy_o),
        .mmu_req_vld_o(mmu_req_vld_o), .mmu_req_trans_id_o(mmu_req_trans_id_o),
        .mmu_req_asid_o(mmu_req_asid_o), .mmu_req_vpn_o(mmu_req_vpn_o),
        .mmu_req_access_type_o(mmu_req_access_type_o), .mmu_req_rdy_i(mmu_req_rdy_i),
        .mmu_resp_vld_i(mmu_resp_vld_i), .mmu_resp_pte_i(mmu_resp_pte_i),
        .mmu_resp_page_lvl_i(mmu_resp_page_lvl_i),
        .mmu_resp_access_fault_i(mmu_resp_access_fault_i),
        .mmu_resp_page_fault_i(mmu_resp_page_fault_i),
        .tlb_resp_vld_o(tlb_resp_vld_o), .tlb_resp_wake_mask_o(tlb_resp_wake_mask_o),
        .tlb_resp_asid_o(tlb_resp_asid_o), .tlb_resp_vpn_o(tlb_resp_vpn_o),
        .tlb_resp_access_type_o(tlb_resp_access_type_o), .tlb_resp_pte_o(tlb_resp_pte_o),
        .tlb_resp_page_lvl_o(tlb_resp_page_lvl_o),
        .tlb_resp_access_fault_o(tlb_resp_access_fault_o),
        .tlb_resp_page_fault_o(tlb_resp_page_fault_o),
        .tlb_resp_stale_o(tlb_resp_stale_o)
    );

    typedef struct {
        logic [AW-1:0] asid;
        logic [VW-1:0] vpn;
        logic [1:0]    at;
        logic [TW-1:0] id;
        logic [MW-1:0] mask;
    } ment_t;

    // Reference model: outstanding misses in order, plus where the head is.
    ment_t         mq[$];
    bit            m_issue, m_wait, m_stale;
    int            m_wait_cyc;
    bit            e_rvld, e_stale, e_af, e_pf;
    ment_t         e_rent;
    logic [PW-1:0] e_pte;
    logic [LW-1:0] e_lvl;

    int            n_cmp = 0;
    int            n_mis = 0;
    int            obs_resp, obs_hs;
    logic [MW-1:0] obs_mask;
    logic          obs_stale, obs_rdy;
    bit            auto_mmu, resp_en;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_match();
        for (int k = 0; k < mq.size(); k++) begin
            if (k == 0 && m_wait && mmu_resp_vld_i) continue;
            if (mq[k].asid == tlb_req_asid_i && mq[k].vpn == tlb_req_vpn_i &&
                mq[k].at == tlb_req_access_type_i) return k;
        end
        return -1;
    endfunction

    task automatic step();
        int    k;
        bit    exp_rdy, pop, acc, was_nonempty;
        ment_t ne;
        if (auto_mmu) begin
            mmu_req_rdy_i  = 1'b1;
            mmu_resp_vld_i = resp_en && m_wait && (m_wait_cyc >= 2);
        end
        mmu_resp_pte_i          = {$urandom, $urandom};
        mmu_resp_page_lvl_i     = LW'($urandom_range(0, 2));
        mmu_resp_access_fault_i = 1'($urandom);
        mmu_resp_page_fault_i   = 1'($urandom);
        @(negedge clk);
        k       = model_match();
        exp_rdy = !flush_i && (k >= 0 || mq.size() < N);
        check_eq("req_rdy", tlb_req_rdy_o, exp_rdy);
        check_eq("mmu_vld", mmu_req_vld_o, m_issue);
        if (m_issue) begin
            check_eq("mmu_asid", mmu_req_asid_o, mq[0].asid);
            check_eq("mmu_vpn", mmu_req_vpn_o, mq[0].vpn);
            check_eq("mmu_type", mmu_req_access_type_o, mq[0].at);
            check_eq("mmu_id", mmu_req_trans_id_o, mq[0].id);
        end
        check_eq("resp_vld", tlb_resp_vld_o, e_rvld);
        if (e_rvld) begin
            check_eq("resp_mask", tlb_resp_wake_mask_o, e_rent.mask);
            check_eq("resp_asid", tlb_resp_asid_o, e_rent.asid);
            check_eq("resp_vpn", tlb_resp_vpn_o, e_rent.vpn);
            check_eq("resp_type", tlb_resp_access_type_o, e_rent.at);
            check_eq("resp_pte", tlb_resp_pte_o, e_pte);
            check_eq("resp_lvl", tlb_resp_page_lvl_o, e_lvl);
            check_eq("resp_af", tlb_resp_access_fault_o, e_af);
            check_eq("resp_pf", tlb_resp_page_fault_o, e_pf);
            check_eq("resp_stale", tlb_resp_stale_o, e_stale);
        end
        obs_rdy = tlb_req_rdy_o;
        if (tlb_resp_vld_o) begin
            obs_resp++;
            obs_mask  = tlb_resp_wake_mask_o;
            obs_stale = tlb_resp_stale_o;
        end
        if (mmu_req_vld_o && mmu_req_rdy_i) obs_hs++;
        @(posedge clk);
        pop          = m_wait && mmu_resp_vld_i;
        acc          = tlb_req_vld_i && exp_rdy;
        was_nonempty = mq.size() > 0;
        e_rvld       = pop;
        if (pop) begin
            e_rent  = mq[0];
            e_pte   = mmu_resp_pte_i;
            e_lvl   = mmu_resp_page_lvl_i;
            e_af    = mmu_resp_access_fault_i;
            e_pf    = mmu_resp_page_fault_i;
            e_stale = m_stale || flush_i;
        end
        if (acc) begin
            if (k >= 0) begin
                mq[k].mask[tlb_req_trans_id_i] = 1'b1;
            end else begin
                ne.asid = tlb_req_asid_i;
                ne.vpn  = tlb_req_vpn_i;
                ne.at   = tlb_req_access_type_i;
                ne.id   = tlb_req_trans_id_i;
                ne.mask = '0;
                ne.mask[tlb_req_trans_id_i] = 1'b1;
                mq.push_back(ne);
            end
        end
        if (pop) void'(mq.pop_front());
        if (flush_i) begin
            if (pop || !(m_issue || m_wait)) mq.delete();
            else while (mq.size() > 1) void'(mq.pop_back());
        end
        if (pop) m_stale = 1'b0;
        else if (flush_i && (m_issue || m_wait)) m_stale = 1'b1;
        if (m_issue) begin
            if (mmu_req_rdy_i) begin
                m_issue    = 1'b0;
                m_wait     = 1'b1;
                m_wait_cyc = 0;
            end
        end else if (m_wait) begin
            if (pop) begin
                m_wait  = 1'b0;
                m_issue = mq.size() > 0;
            end else begin
                m_wait_cyc++;
            end
        end else if (was_nonempty && !flush_i) begin
            m_issue = 1'b1;
        end
        #1;
    endtask

    task automatic req(input int id, input int asid, input int vpn, input logic [1:0] at);
        tlb_req_vld_i         = 1'b1;
        tlb_req_trans_id_i    = TW'(id);
        tlb_req_asid_i        = AW'(asid);
        tlb_req_vpn_i         = VW'(vpn);
        tlb_req_access_type_i = at;
        step();
        tlb_req_vld_i = 1'b0;
    endtask

    task automatic drain(input int cycles);
        auto_mmu = 1'b1;
        resp_en  = 1'b1;
        flush_i  = 1'b0;
        repeat (cycles) step();
    endtask

    task automatic clear_obs();
        obs_resp  = 0;
        obs_hs    = 0;
        obs_mask  = '0;
        obs_stale = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        tlb_req_vld_i = 1'b0;
        tlb_req_trans_id_i = '0;
        tlb_req_asid_i = '0;
        tlb_req_vpn_i = '0;
        tlb_req_access_type_i = ACCESS_R;
        mmu_req_rdy_i = 1'b0;
        mmu_resp_vld_i = 1'b0;
        mmu_resp_pte_i = '0;
        mmu_resp_page_lvl_i = '0;
        mmu_resp_access_fault_i = 1'b0;
        mmu_resp_page_fault_i = 1'b0;
        auto_mmu = 1'b1;
        resp_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rdy", tlb_req_rdy_o, 1);
        check_eq("rst_mmu_vld", mmu_req_vld_o, 0);
        check_eq("rst_resp_vld", tlb_resp_vld_o, 0);
        check_eq("rst_resp_mask", tlb_resp_wake_mask_o, 0);
        check_eq("rst_resp_pte", tlb_resp_pte_o, 0);
        check_eq("rst_resp_stale", tlb_resp_stale_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_issue = 0; m_wait = 0; m_stale = 0; m_wait_cyc = 0; e_rvld = 0;

        // single miss
        clear_obs();
        req(2, 1, 'h12345, ACCESS_R);
        drain(10);
        check_eq("single_cnt", obs_resp, 1);
        check_eq("single_mask", obs_mask, 'h04);
        check_eq("single_stale", obs_stale, 0);

        // duplicate merges into one walk
        clear_obs();
        req(1, 1, 'h12345, ACCESS_R);
        req(5, 1, 'h12345, ACCESS_R);
        drain(10);
        check_eq("dup_hs", obs_hs, 1);
        check_eq("dup_mask", obs_mask, 'h22);

        // same vpn, different access type
        clear_obs();
        req(0, 1, 'h12345, ACCESS_R);
        req(1, 1, 'h12345, ACCESS_X);
        drain(16);
        check_eq("rx_hs", obs_hs, 2);
        check_eq("rx_last_mask", obs_mask, 'h02);

        // fill with MMU stalled, refuse a 5th distinct, merge a 5th duplicate
        clear_obs();
        auto_mmu = 1'b0;
        mmu_req_rdy_i = 1'b0;
        mmu_resp_vld_i = 1'b0;
        for (int i = 0; i < 4; i++) req(i, 3, 'h100 + i, ACCESS_W);
        req(4, 3, 'h200, ACCESS_W);
        check_eq("full_refuse", obs_rdy, 0);
        req(7, 3, 'h102, ACCESS_W);
        check_eq("full_merge", obs_rdy, 1);
        drain(30);
        check_eq("fill_resp_cnt", obs_resp, 4);

        // flush with head in WAIT and two queued behind it
        clear_obs();
        auto_mmu = 1'b1;
        resp_en = 1'b0;
        req(1, 4, 'h300, ACCESS_R);
        req(2, 4, 'h301, ACCESS_R);
        req(3, 4, 'h302, ACCESS_R);
        for (int i = 0; i < 10 && !m_wait; i++) step();
        check_eq("flush_head_hs", obs_hs, 1);
        flush_i = 1'b1;
        step();
        drain(12);
        check_eq("flush_resp_cnt", obs_resp, 1);
        check_eq("flush_stale", obs_stale, 1);
        check_eq("flush_no_reissue", obs_hs, 1);

        // response coincides with a new miss to the same page
        clear_obs();
        resp_en = 1'b0;
        req(0, 5, 'h400, ACCESS_R);
        for (int i = 0; i < 10 && !m_wait; i++) step();
        auto_mmu = 1'b0;
        mmu_resp_vld_i = 1'b1;
        req(3, 5, 'h400, ACCESS_R);
        check_eq("resp_push_rdy", obs_rdy, 1);
        mmu_resp_vld_i = 1'b0;
        drain(12);
        check_eq("resp_push_hs", obs_hs, 2);
        check_eq("resp_push_mask", obs_mask, 'h08);

        // random traffic
        auto_mmu = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tlb_req_vld_i         = 1'($urandom);
            tlb_req_trans_id_i    = TW'($urandom);
            tlb_req_asid_i        = AW'($urandom_range(1, 2));
            tlb_req_vpn_i         = VW'('h12345 + $urandom_range(0, 2));
            tlb_req_access_type_i = 2'($urandom_range(0, 2));
            flush_i               = ($urandom_range(0, 19) == 0);
            mmu_req_rdy_i         = 1'($urandom);
            mmu_resp_vld_i        = m_wait && ($urandom_range(0, 2) == 0);
            step();
        end
        tlb_req_vld_i = 1'b0;
        drain(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
